// File: rtl/spi_frame_parser.sv
// Purpose: decodes the NSS-framed host command stream from the SPI byte receiver and pushes only line-address and pixel bytes into the async FIFO.
// Latency: a push appears on o_wdata/o_winc 1 cycle after the accepted byte strobe; NSS frame end is seen 3 cycles after the raw rising edge.
// Backpressure: i_wfull drops (and counts) address/pixel bytes without shortening the line; padding stalls while full; strobes during padding are discarded and counted.
//
// Ports:
//   i_clk, i_reset                 clock (also FIFO write clock), synchronous active-high reset
//   i_rx_data, i_rx_dataValid      received SPI byte and its one-cycle strobe
//   i_spi_nss                      raw active-low chip select, asynchronous to i_clk
//   i_wfull                        FIFO full flag, write domain
//   o_wdata, o_winc                FIFO write data and one-cycle write enable
//   o_clear                        one-cycle pulse on CLEAR command
//   o_line_busy                    high while a line is in progress (ADDR, DATA, PAD)
//   o_overflow                     sticky: an address/pixel byte was dropped on a full FIFO
//   o_frame_err                    one-cycle pulse on a protocol error
//   o_drop_count                   saturating count of every dropped/discarded byte
module spi_frame_parser #(
    parameter int          LINES          = 240,
    parameter int          BYTES_PER_LINE = 64,
    parameter logic [7:0]  PAD_BYTE       = 8'h00,
    parameter int          CNT_WIDTH      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_dataValid,
    input  logic                 i_spi_nss,
    input  logic                 i_wfull,
    output logic [7:0]           o_wdata,
    output logic                 o_winc,
    output logic                 o_clear,
    output logic                 o_line_busy,
    output logic                 o_overflow,
    output logic                 o_frame_err,
    output logic [CNT_WIDTH-1:0] o_drop_count
);

    localparam int             LCW      = $clog2(BYTES_PER_LINE + 1);
    localparam logic [LCW-1:0] LAST_IDX = LCW'(BYTES_PER_LINE - 1);
    localparam logic [LCW-1:0] LINE_LEN = LCW'(BYTES_PER_LINE);

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_CLEAR = 8'h02;

    // Bit 2 of the encoding marks the line-busy states, so o_line_busy is a
    // straight flop output with no decode.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_SKIP = 3'b001,
        ST_ADDR = 3'b100,
        ST_DATA = 3'b101,
        ST_PAD  = 3'b110
    } state_t;

    state_t         state;
    logic [LCW-1:0] line_cnt;   // index of the next pixel byte within the line
    logic [LCW-1:0] remaining;  // pad bytes still owed to the FIFO

    // ------------------------------------------------------------------
    // NSS synchronizer and rising-edge (frame end) detect
    // ------------------------------------------------------------------
    logic nss_meta;
    logic nss_sync;
    logic nss_prev;
    logic frame_end;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            nss_meta <= 1'b1;
            nss_sync <= 1'b1;
            nss_prev <= 1'b1;
        end else begin
            nss_meta <= i_spi_nss;
            nss_sync <= nss_meta;
            nss_prev <= nss_sync;
        end
    end

    assign frame_end = nss_sync & ~nss_prev;

    // ------------------------------------------------------------------
    // Write / drop decision for the current cycle
    // ------------------------------------------------------------------
    logic addr_ok;
    logic byte_push;   // a received byte wants to go into the FIFO
    logic pad_push;    // a pad byte goes into the FIFO
    logic drop_evt;
    logic ovf_evt;
    logic wr_en;

    assign addr_ok = int'(i_rx_data) < LINES;

    always_comb begin
        byte_push = 1'b0;
        pad_push  = 1'b0;
        drop_evt  = 1'b0;
        ovf_evt   = 1'b0;
        unique case (state)
            ST_ADDR: byte_push = i_rx_dataValid && addr_ok;
            ST_DATA: byte_push = i_rx_dataValid;
            ST_PAD: begin
                pad_push = !i_wfull;
                drop_evt = i_rx_dataValid;   // discarded, but not an overflow
            end
            default: ;
        endcase
        if (byte_push && i_wfull) begin
            drop_evt = 1'b1;
            ovf_evt  = 1'b1;
        end
    end

    assign wr_en = (byte_push && !i_wfull) || pad_push;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wdata      <= 8'h00;
            o_winc       <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else begin
            o_winc <= wr_en;
            if (wr_en) begin
                o_wdata <= pad_push ? PAD_BYTE : i_rx_data;
            end
            if (ovf_evt) begin
                o_overflow <= 1'b1;
            end
            if (drop_evt && (o_drop_count != '1)) begin
                o_drop_count <= o_drop_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM. A byte strobe coinciding with frame end is applied
    // first; the frame-end action then acts on the post-byte state.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            line_cnt    <= '0;
            remaining   <= '0;
            o_clear     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_clear     <= 1'b0;
            o_frame_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_rx_dataValid) begin
                        case (i_rx_data)
                            CMD_NOP: ;
                            CMD_WRITE: begin
                                // Frame ended right after the command: no address.
                                if (frame_end) o_frame_err <= 1'b1;
                                else           state       <= ST_ADDR;
                            end
                            CMD_CLEAR: o_clear <= 1'b1;
                            default: begin
                                o_frame_err <= 1'b1;
                                state       <= frame_end ? ST_IDLE : ST_SKIP;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (i_rx_dataValid) begin
                        if (addr_ok) begin
                            line_cnt <= '0;
                            if (frame_end) begin
                                o_frame_err <= 1'b1;
                                remaining   <= LINE_LEN;
                                state       <= ST_PAD;
                            end else begin
                                state <= ST_DATA;
                            end
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= frame_end ? ST_IDLE : ST_SKIP;
                        end
                    end else if (frame_end) begin
                        o_frame_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (i_rx_dataValid) begin
                        // Counter advances even when the byte is dropped on full.
                        if (line_cnt == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                            if (frame_end) begin
                                o_frame_err <= 1'b1;
                                remaining   <= LINE_LEN - line_cnt - 1'b1;
                                state       <= ST_PAD;
                            end
                        end
                    end else if (frame_end) begin
                        o_frame_err <= 1'b1;
                        remaining   <= LINE_LEN - line_cnt;
                        state       <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (!i_wfull) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LCW'(1)) state <= ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    if (frame_end) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_line_busy = state[2];

endmodule

// File: tb/tb_spi_frame_parser.sv
module tb_spi_frame_parser;

    localparam int         LINES = 240;
    localparam int         BPL   = 64;
    localparam logic [7:0] PAD   = 8'h00;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_dataValid;
    logic       i_spi_nss;
    logic       i_wfull;
    logic [7:0] o_wdata;
    logic       o_winc;
    logic       o_clear;
    logic       o_line_busy;
    logic       o_overflow;
    logic       o_frame_err;
    logic [7:0] o_drop_count;

    spi_frame_parser dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_rx_data      (i_rx_data),
        .i_rx_dataValid (i_rx_dataValid),
        .i_spi_nss      (i_spi_nss),
        .i_wfull        (i_wfull),
        .o_wdata        (o_wdata),
        .o_winc         (o_winc),
        .o_clear        (o_clear),
        .o_line_busy    (o_line_busy),
        .o_overflow     (o_overflow),
        .o_frame_err    (o_frame_err),
        .o_drop_count   (o_drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    int         err_seen  = 0;
    int         clr_seen  = 0;
    int         full_viol = 0;
    logic       last_wfull = 1'b0;

    always @(negedge clk) begin
        if (o_winc === 1'b1) begin
            got_q.push_back(o_wdata);
            if (last_wfull) full_viol++;
        end
        if (o_frame_err === 1'b1) err_seen++;
        if (o_clear === 1'b1) clr_seen++;
        last_wfull = i_wfull;
    end

    // ---------------- reference model ----------------
    logic [7:0] fb[$];   // frame bytes
    bit         ff[$];   // FIFO full at that byte's strobe
    logic [7:0] exp_q[$];
    int         exp_err  = 0;
    int         exp_clr  = 0;
    int         exp_drop = 0;
    bit         exp_ovf  = 1'b0;

    task automatic model_drop();
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic model_take(input logic [7:0] b, input bit f);
        if (f) begin
            exp_ovf = 1'b1;
            model_drop();
        end else begin
            exp_q.push_back(b);
        end
    endtask

    // Interprets one whole frame: mode 0 idle, 1 expecting address,
    // 2 collecting pixels, 3 ignoring until frame end.
    task automatic model_frame(input int pad_strobes);
        int mode = 0;
        int pix  = 0;
        foreach (fb[i]) begin
            case (mode)
                0: begin
                    if (fb[i] == 8'h01)      mode = 1;
                    else if (fb[i] == 8'h02) exp_clr++;
                    else if (fb[i] != 8'h00) begin exp_err++; mode = 3; end
                end
                1: begin
                    if (int'(fb[i]) < LINES) begin
                        model_take(fb[i], ff[i]);
                        pix  = 0;
                        mode = 2;
                    end else begin
                        exp_err++;
                        mode = 3;
                    end
                end
                2: begin
                    model_take(fb[i], ff[i]);
                    pix++;
                    if (pix == BPL) mode = 0;
                end
                default: ;
            endcase
        end
        if (mode == 1) exp_err++;
        if (mode == 2) begin
            exp_err++;
            repeat (BPL - pix) exp_q.push_back(PAD);
            repeat (pad_strobes) model_drop();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] b, input bit f);
        fb.push_back(b);
        ff.push_back(f);
    endtask

    task automatic add_line(input logic [7:0] addr, input int n, input logic [7:0] first);
        add(8'h01, 1'b0);
        add(addr, 1'b0);
        for (int i = 0; i < n; i++) add(first + 8'(i), 1'b0);
    endtask

    task automatic strobe(input logic [7:0] b, input bit f);
        i_rx_data      = b;
        i_wfull        = f;
        i_rx_dataValid = 1'b1;
        step();
        i_rx_dataValid = 1'b0;
        i_wfull        = 1'b0;
    endtask

    task automatic compare_frame(input string name);
        chk({name, ":npush"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk({name, ":push_dat"}, got_q[i], exp_q[i]);
            if (got_q[i] !== exp_q[i]) break;
        end
        chk({name, ":frame_err"}, err_seen, exp_err);
        chk({name, ":clear"}, clr_seen, exp_clr);
        chk({name, ":overflow"}, o_overflow, exp_ovf);
        chk({name, ":drop_count"}, o_drop_count, exp_drop);
        chk({name, ":push_on_full"}, full_viol, 0);
        got_q.delete();
        exp_q.delete();
        fb.delete();
        ff.delete();
    endtask

    task automatic send_frame(input string name, input bit pad_rand, input int pad_strobes);
        int waited = 0;
        i_spi_nss = 1'b0;
        repeat (3) step();
        foreach (fb[i]) begin
            strobe(fb[i], ff[i]);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (2) step();
        i_spi_nss = 1'b1;
        if (pad_strobes > 0) begin
            // stall the padding, then hit it with strobes that must be discarded
            i_wfull = 1'b1;
            repeat (6) step();
            repeat (pad_strobes) begin
                i_rx_data      = 8'($urandom);
                i_rx_dataValid = 1'b1;
                step();
                i_rx_dataValid = 1'b0;
                step();
            end
            i_wfull = 1'b0;
        end else begin
            repeat (5) step();
        end
        while (o_line_busy === 1'b1 && waited < 3000) begin
            i_wfull = pad_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            waited++;
        end
        i_wfull = 1'b0;
        chk({name, ":line_done"}, o_line_busy, 1'b0);
        repeat (4) step();
        model_frame(pad_strobes);
        compare_frame(name);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        i_reset        = 1'b1;
        i_rx_data      = 8'h00;
        i_rx_dataValid = 1'b0;
        i_spi_nss      = 1'b1;
        i_wfull        = 1'b0;
        repeat (4) step();
        chk("rst:winc", o_winc, 1'b0);
        chk("rst:wdata", o_wdata, 8'h00);
        chk("rst:clear", o_clear, 1'b0);
        chk("rst:busy", o_line_busy, 1'b0);
        chk("rst:overflow", o_overflow, 1'b0);
        chk("rst:frame_err", o_frame_err, 1'b0);
        chk("rst:drop_count", o_drop_count, 8'h00);
        i_reset = 1'b0;
        repeat (3) step();

        // clean line
        add_line(8'h05, 64, 8'h10);
        send_frame("clean", 1'b0, 0);

        // truncated line, then again with FIFO full toggling during padding
        add_line(8'h07, 10, 8'hA0);
        send_frame("trunc", 1'b0, 0);
        add_line(8'h07, 10, 8'hB0);
        send_frame("trunc_stall", 1'b1, 0);

        // bad address then a normal line
        add_line(8'hF0, 3, 8'h01);
        send_frame("bad_addr", 1'b0, 0);
        add_line(8'h00, 64, 8'h80);
        send_frame("after_bad", 1'b0, 0);

        // three full-FIFO drops mid-line
        add(8'h01, 1'b0);
        add(8'h09, 1'b0);
        for (int i = 0; i < 64; i++) add(8'(i + 3), (i >= 20 && i < 23));
        send_frame("overflow", 1'b0, 0);

        // strobes during padding are discarded
        add_line(8'h04, 5, 8'h60);
        send_frame("pad_drop", 1'b0, 3);

        // command mix, then a junk command that skips the rest of the frame
        add(8'h00, 1'b0);
        add(8'h02, 1'b0);
        add_line(8'h02, 64, 8'hC0);
        send_frame("cmds", 1'b0, 0);
        add(8'h55, 1'b0);
        add(8'h01, 1'b0);
        add(8'h02, 1'b0);
        send_frame("junk", 1'b0, 0);

        // drop counter saturation
        for (int l = 0; l < 5; l++) begin
            add(8'h01, 1'b1);
            add(8'(l), 1'b1);
            for (int i = 0; i < 64; i++) add(8'(i), 1'b1);
        end
        send_frame("saturate", 1'b0, 0);

        // reset in the middle of a line
        i_spi_nss = 1'b0;
        repeat (3) step();
        strobe(8'h01, 1'b0);
        strobe(8'h03, 1'b0);
        for (int i = 0; i < 20; i++) begin
            strobe(8'(8'h40 + i), (i == 5));
            if (i == 5) begin
                exp_ovf = 1'b1;
                model_drop();
            end
        end
        step();
        chk("midrst:busy_before", o_line_busy, 1'b1);
        chk("midrst:pushes_before", got_q.size(), 20);
        chk("midrst:drop_before", o_drop_count, exp_drop);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        got_q.delete();
        chk("midrst:winc", o_winc, 1'b0);
        chk("midrst:busy", o_line_busy, 1'b0);
        chk("midrst:overflow", o_overflow, 1'b0);
        chk("midrst:drop_count", o_drop_count, 8'h00);
        repeat (70) step();
        i_spi_nss = 1'b1;
        repeat (6) step();
        chk("midrst:no_pad", got_q.size(), 0);
        chk("midrst:no_err", err_seen, exp_err);
        exp_ovf  = 1'b0;
        exp_drop = 0;
        add_line(8'hEF, 64, 8'h20);
        send_frame("post_rst", 1'b0, 0);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            int nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) begin
                int r = $urandom_range(0, 9);
                if (r == 0) begin
                    add(8'h00, 1'b0);
                end else if (r == 1) begin
                    add(8'h02, 1'b0);
                end else if (r == 2) begin
                    add(8'($urandom_range(3, 255)), 1'b0);
                end else begin
                    int len = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : 64;
                    logic [7:0] addr;
                    addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(240, 255))
                                                       : 8'($urandom_range(0, 239));
                    add(8'h01, 1'b0);
                    add(addr, ($urandom_range(0, 9) == 0));
                    for (int i = 0; i < len; i++)
                        add(8'($urandom), ($urandom_range(0, 9) == 0));
                end
            end
            send_frame("rand", 1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case the sequence itself wedges
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
